// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on a shared shift-add / restoring-divide datapath.
module muldiv_unit #(
   parameter int XLEN         = 32,
   parameter bit FAST_SPECIAL = 1'b1
) (
   input  logic            CLK,
   input  logic            CLR,
   input  logic            START,
   input  logic            FLUSH,
   input  logic [2:0]      FUNCT3,
   input  logic [XLEN-1:0] SRC_A,
   input  logic [XLEN-1:0] SRC_B,
   input  logic [4:0]      RD_IN,
   output logic            BUSY,
   output logic            DONE,
   output logic [XLEN-1:0] RESULT,
   output logic [4:0]      RD_OUT,
   output logic            WE_OUT
);
   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   state_t state, state_nx;
   logic [XLEN-1:0] hi, lo, bv, a_raw;
   logic [2:0] op;
   logic [4:0] cnt, rd;
   logic neg, dz, ovf;
   logic sgn_a, sgn_b, start_dz, start_ovf, start_neg, go, ge;
   logic [XLEN-1:0] abs_a, abs_b, q, r, fin_val;
   logic [XLEN:0] sum, sh, diff;
   logic [2*XLEN-1:0] prod_s;
   always_comb begin
      sgn_a     = (FUNCT3 == 3'd1 || FUNCT3 == 3'd2 || FUNCT3 == 3'd4 || FUNCT3 == 3'd6) && SRC_A[XLEN-1];
      sgn_b     = (FUNCT3 == 3'd1 || FUNCT3 == 3'd4 || FUNCT3 == 3'd6) && SRC_B[XLEN-1];
      abs_a     = sgn_a ? -SRC_A : SRC_A;
      abs_b     = sgn_b ? -SRC_B : SRC_B;
      start_dz  = FUNCT3[2] && SRC_B == '0;
      start_ovf = FUNCT3[2] && !FUNCT3[0] && SRC_A == MIN_NEG && SRC_B == '1;
      start_neg = (FUNCT3[2] && FUNCT3[1]) ? sgn_a : sgn_a ^ sgn_b;
      go        = START && !FLUSH && state == IDLE;
      state_nx  = FLUSH ? IDLE :
                  state == IDLE ? (START ? ((FAST_SPECIAL && (start_dz || start_ovf)) ? FIN : CALC) : IDLE) :
                  state == CALC ? (cnt == 5'd31 ? FIN : CALC) : IDLE;
   end
   // One iteration step: multiply adds then shifts right, divide shifts left then trial-subtracts.
   always_comb begin
      sum    = {1'b0, hi} + {1'b0, lo[0] ? bv : '0};
      sh     = {hi, lo[XLEN-1]};
      diff   = sh - {1'b0, bv};
      ge     = !diff[XLEN];
      prod_s = neg ? -{hi, lo} : {hi, lo};
      q      = neg ? -lo : lo;
      r      = neg ? -hi : hi;
      fin_val = dz ? (op[1] ? a_raw : '1) :
                ovf ? (op[1] ? '0 : MIN_NEG) :
                !op[2] ? (op[1:0] == 2'd0 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN]) :
                op[1] ? r : q;
   end
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) state <= IDLE;
      else state <= state_nx;
   end
   assign BUSY = state != IDLE;
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         hi <= '0;
         lo <= '0;
         bv <= '0;
         a_raw <= '0;
         op <= '0;
         cnt <= '0;
         rd <= '0;
         neg <= 1'b0;
         dz <= 1'b0;
         ovf <= 1'b0;
         DONE <= 1'b0;
         WE_OUT <= 1'b0;
         RESULT <= '0;
         RD_OUT <= '0;
      end else begin
         DONE <= 1'b0;
         WE_OUT <= 1'b0;
         if (go) begin
            op <= FUNCT3;
            rd <= RD_IN;
            cnt <= '0;
            hi <= '0;
            lo <= FUNCT3[2] ? abs_a : abs_b;
            bv <= FUNCT3[2] ? abs_b : abs_a;
            a_raw <= SRC_A;
            neg <= start_neg;
            dz <= start_dz;
            ovf <= start_ovf;
         end else if (state == CALC && !FLUSH) begin
            cnt <= cnt + 5'd1;
            hi <= op[2] ? (ge ? diff[XLEN-1:0] : sh[XLEN-1:0]) : sum[XLEN:1];
            lo <= op[2] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
         end else if (state == FIN && !FLUSH) begin
            RESULT <= fin_val;
            RD_OUT <= rd;
            DONE <= 1'b1;
            WE_OUT <= rd != 5'd0;
         end
      end
   end
endmodule
